pipelined_xor_reducer: RTL

// Parametrised, pipelined XOR-reduction (parity) engine built from gf180mcu xor2 cells.

---
 rtl/pipelined_xor_reducer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipelined_xor_reducer.sv
// Pipelined XOR-reduction (parity) engine: a balanced xor tree registered every LEVELS_PER_STAGE
// levels, with a global valid/ready stall and optional parity accumulation across multi-beat packets.
module pipelined_xor_reducer #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter bit INVERT           = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             busy
);

  localparam int LPS     = (LEVELS_PER_STAGE < 1) ? 1 : LEVELS_PER_STAGE;
  localparam int LOG2W   = $clog2(WIDTH);
  localparam int LAT_RAW = (LOG2W + LPS - 1) / LPS;
  localparam int LATENCY = (LAT_RAW < 1) ? 1 : LAT_RAW;
  localparam int GROUP   = 1 << LPS;

  // Bit offset of stage k inside the packed vector that holds every stage's partial result.
  function automatic int stage_off(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += WIDTH >> (i * LPS);
    return s;
  endfunction

  localparam int TOTAL    = stage_off(LATENCY);
  localparam int LAST_OFF = stage_off(LATENCY - 1);
  localparam int LAST_W   = WIDTH >> ((LATENCY - 1) * LPS);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_xor_reducer: WIDTH must be a power of two >= 2");
  end
  if (LEVELS_PER_STAGE < 1) begin : g_bad_levels
    $error("pipelined_xor_reducer: LEVELS_PER_STAGE must be >= 1");
  end

  logic [LATENCY-1:0] stg_valid_q, stg_valid_d;
  logic [LATENCY-1:0] stg_acc_q,   stg_acc_d;
  logic [LATENCY-1:0] stg_last_q,  stg_last_d;
  logic [TOTAL-1:0]   stg_data_q,  stg_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_data_q,  out_data_d;
  logic               acc_q,       acc_d;
  logic               acc_pend_q,  acc_pend_d;
  logic               advance;
  logic               final_r;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage 0 registers the raw beat; each later stage folds GROUP-bit groups of the previous one.
  assign stg_data_d[WIDTH-1:0] = in_data;
  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    localparam int SW  = WIDTH >> (k * LPS);
    localparam int CUR = stage_off(k);
    localparam int PRV = stage_off(k - 1);
    for (genvar j = 0; j < SW; j++) begin : g_bit
      assign stg_data_d[CUR + j] = ^stg_data_q[PRV + j*GROUP +: GROUP];
    end
  end

  assign final_r = ^stg_data_q[LAST_OFF +: LAST_W];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stg_valid_d = stg_valid_q;
    stg_acc_d   = stg_acc_q;
    stg_last_d  = stg_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    acc_pend_d  = acc_pend_q;
    if (advance) begin
      stg_valid_d[0] = in_valid;
      stg_acc_d[0]   = in_acc;
      stg_last_d[0]  = in_last;
      for (int k = 1; k < LATENCY; k++) begin
        stg_valid_d[k] = stg_valid_q[k-1];
        stg_acc_d[k]   = stg_acc_q[k-1];
        stg_last_d[k]  = stg_last_q[k-1];
      end
      // Output either handshook or was empty; it only stays valid if a new result lands now.
      out_valid_d = 1'b0;
      if (stg_valid_q[LATENCY-1]) begin
        if (!stg_acc_q[LATENCY-1]) begin
          out_valid_d = 1'b1;
          out_data_d  = final_r ^ INVERT;
        end else if (!stg_last_q[LATENCY-1]) begin
          acc_d      = acc_q ^ final_r;
          acc_pend_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q ^ final_r ^ INVERT;
          acc_d       = 1'b0;
          acc_pend_d  = 1'b0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid_q <= '0;
      stg_acc_q   <= '0;
      stg_last_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      acc_q       <= 1'b0;
      acc_pend_q  <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_acc_q   <= stg_acc_d;
      stg_last_q  <= stg_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
      acc_pend_q  <= acc_pend_d;
    end
  end

  // NOTE: the tree datapath is left unreset; its contents are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (advance) stg_data_q <= stg_data_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (|stg_valid_q) | out_valid_q | acc_pend_q;

endmodule
